hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_if.sv | 35 +++
 rtl/hazard_unit.sv | 57 +++++
 2 files changed

// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-unit signal bundle; master drives stage status, slave returns stage controls.
interface hazard_if;
    logic        IDEX_mem_read;
    logic [4:0]  IDEX_rd;
    logic [4:0]  IFID_rs1;
    logic [4:0]  IFID_rs2;
    logic        IFID_uses_rs1;
    logic        IFID_uses_rs2;
    logic        EXMEM_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        PC_write;
    logic        IFID_write;
    logic        IDEX_write;
    logic        EXMEM_write;
    logic        IDEX_bubble;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        MEMWB_bubble;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    modport master (
        output IDEX_mem_read, IDEX_rd, IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
               EXMEM_branch_taken, dmem_req, dmem_ready,
        input  PC_write, IFID_write, IDEX_write, EXMEM_write, IDEX_bubble, IFID_flush,
               IDEX_flush, MEMWB_bubble, mem_timeout, stall_cycles, flush_count
    );
    modport slave (
        input  IDEX_mem_read, IDEX_rd, IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
               EXMEM_branch_taken, dmem_req, dmem_ready,
        output PC_write, IFID_write, IDEX_write, EXMEM_write, IDEX_bubble, IFID_flush,
               IDEX_flush, MEMWB_bubble, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control with memory-wait tracking, timeout flag and event counters.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input logic clk,
    input logic r,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;
    // Control word: {PC_w, IFID_w, IDEX_w, EXMEM_w, IDEX_bubble, IFID_flush, IDEX_flush, MEMWB_bubble}
    localparam logic [7:0] CTL_DEF = 8'b1111_0000;
    localparam logic [7:0] CTL_FRZ = 8'b0000_0001;
    localparam logic [7:0] CTL_BR  = 8'b1111_0110;
    localparam logic [7:0] CTL_LU  = 8'b0011_1000;
    localparam logic [15:0] TO = 16'(MEM_TIMEOUT);
    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_timeout;
    logic [31:0] r_stall;
    logic [31:0] r_flush;
    logic        w_mem_stall;
    logic        w_load_use;
    logic [7:0]  w_ctl;
    assign w_mem_stall = hz.dmem_req & ~hz.dmem_ready;
    assign w_load_use  = hz.IDEX_mem_read & (hz.IDEX_rd != 5'd0) &
                         ((hz.IFID_uses_rs1 & (hz.IDEX_rd == hz.IFID_rs1)) |
                          (hz.IFID_uses_rs2 & (hz.IDEX_rd == hz.IFID_rs2)));
    always_comb begin
        w_ctl = r ? CTL_DEF : w_mem_stall ? CTL_FRZ : hz.EXMEM_branch_taken ? CTL_BR :
                w_load_use ? CTL_LU : CTL_DEF;
    end
    assign {hz.PC_write, hz.IFID_write, hz.IDEX_write, hz.EXMEM_write,
            hz.IDEX_bubble, hz.IFID_flush, hz.IDEX_flush, hz.MEMWB_bubble} = w_ctl;
    assign hz.mem_timeout  = r_timeout;
    assign hz.stall_cycles = r_stall;
    assign hz.flush_count  = r_flush;
    always_ff @(posedge clk) begin
        if (r) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_stall    <= '0;
            r_flush    <= '0;
        end else begin
            r_state <= w_mem_stall ? MEM_WAIT : RUN;
            if (w_mem_stall && r_state == RUN)
                r_wait_cnt <= '0;
            else if (w_mem_stall && r_wait_cnt != TO)
                r_wait_cnt <= r_wait_cnt + 16'd1;
            // Sticky: set on the edge the count lands on TO, never cleared except by reset
            if (w_mem_stall && r_state == MEM_WAIT && r_wait_cnt == TO - 16'd1)
                r_timeout <= 1'b1;
            r_stall <= r_stall + {31'b0, ~w_ctl[7]};
            r_flush <= r_flush + {31'b0, w_ctl[2]};
        end
    end
endmodule
